// File: rtl/cmn_sram_pkg.sv
// cmn_sram_pkg: shared request-type encoding and response-entry sizing for the SRAM val/rdy controller.
package cmn_sram_pkg;

   typedef enum logic {CMN_SRAM_READ, CMN_SRAM_WRITE} cmn_sram_type_t;

   // A queued response is {type, data}.
   function automatic int resp_entry_nbits(input int data_nbits);
      return data_nbits + 1;
   endfunction

endpackage

// File: rtl/cmn_sram_ctrl_resp_queue.sv
// cmn_sram_ctrl_resp_queue: circular FIFO with wrap-around pointers and an occupancy count.
// Depth need not be a power of two; entry storage is not cleared by reset.
module cmn_sram_ctrl_resp_queue
   import cmn_sram_pkg::*;
#(
   parameter int p_nbits = 33,
   parameter int p_depth = 3,
   localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1,
   localparam int c_cnt_nbits = $clog2(p_depth + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_val,
   input  logic [p_nbits-1:0]     enq_data,
   input  logic                   deq,
   output logic [p_nbits-1:0]     deq_data,
   output logic [c_cnt_nbits-1:0] count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_depth - 1);

   logic [p_nbits-1:0]     mem [p_depth];
   logic [c_ptr_nbits-1:0] wr_ptr;
   logic [c_ptr_nbits-1:0] rd_ptr;
   logic                   enq_fire;
   logic                   deq_fire;

   assign full     = count == c_cnt_nbits'(p_depth);
   assign empty    = count == '0;
   assign enq_fire = enq_val && !full;
   assign deq_fire = deq && !empty;
   assign deq_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= (wr_ptr == c_last) ? '0 : wr_ptr + 1'b1;
         if (deq_fire) rd_ptr <= (rd_ptr == c_last) ? '0 : rd_ptr + 1'b1;
         count <= count + c_cnt_nbits'(enq_fire) - c_cnt_nbits'(deq_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) mem[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/cmn_sram_valrdy_ctrl.sv
// cmn_sram_valrdy_ctrl: val/rdy request/response front end for a 1rw synchronous SRAM.
// Optional fired-read/write counters are enabled by CMN_SRAM_VALRDY_CTRL_STATS_EN.
module cmn_sram_valrdy_ctrl
   import cmn_sram_pkg::*;
#(
   parameter int p_data_nbits  = 32,
   parameter int p_num_entries = 256,
   parameter int p_resp_depth  = 3,
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_val,
   output logic                     req_rdy,
   input  logic                     req_type,
   input  logic [c_addr_nbits-1:0]  req_addr,
   input  logic [p_data_nbits-1:0]  req_data,
   input  logic [c_data_nbytes-1:0] req_byte_en,
   output logic                     resp_val,
   input  logic                     resp_rdy,
   output logic                     resp_type,
   output logic [p_data_nbits-1:0]  resp_data,
   output logic                     sram_read_en,
   output logic [c_addr_nbits-1:0]  sram_read_addr,
   input  logic [p_data_nbits-1:0]  sram_read_data,
   output logic                     sram_write_en,
   output logic [c_data_nbytes-1:0] sram_write_byte_en,
   output logic [c_addr_nbits-1:0]  sram_write_addr,
   output logic [p_data_nbits-1:0]  sram_write_data
`ifdef CMN_SRAM_VALRDY_CTRL_STATS_EN
   ,
   input  logic                     stat_clear,
   output logic [31:0]              stat_reads,
   output logic [31:0]              stat_writes
`endif
);

   localparam int c_entry_nbits = resp_entry_nbits(p_data_nbits);
   localparam int c_cnt_nbits   = $clog2(p_resp_depth + 1);

   cmn_sram_type_t           rtype;
   cmn_sram_type_t           inflight_type;
   logic                     inflight_val;
   logic                     fire;
   logic                     q_empty;
   logic                     unused_q_full;
   logic [c_cnt_nbits-1:0]   q_count;
   logic [c_entry_nbits-1:0] q_head;
   logic [c_entry_nbits-1:0] q_enq_data;

   assign rtype = cmn_sram_type_t'(req_type);
   // Ready counts the in-flight slot so the queue can never overflow; no path from resp_rdy.
   assign req_rdy = reset && (int'(q_count) + int'(inflight_val) < p_resp_depth);
   assign fire    = req_val && req_rdy;

   assign sram_read_en       = fire && rtype == CMN_SRAM_READ;
   assign sram_write_en      = fire && rtype == CMN_SRAM_WRITE;
   assign sram_read_addr     = req_addr;
   assign sram_write_addr    = req_addr;
   assign sram_write_data    = req_data;
   assign sram_write_byte_en = req_byte_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_val  <= 1'b0;
         inflight_type <= CMN_SRAM_READ;
      end else begin
         inflight_val  <= fire;
         inflight_type <= rtype;
      end
   end

   assign q_enq_data = {inflight_type == CMN_SRAM_WRITE,
                        inflight_type == CMN_SRAM_WRITE ? '0 : sram_read_data};

   cmn_sram_ctrl_resp_queue #(
      .p_nbits (c_entry_nbits),
      .p_depth (p_resp_depth)
   ) u_resp_queue (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (inflight_val),
      .enq_data (q_enq_data),
      .deq      (resp_rdy),
      .deq_data (q_head),
      .count    (q_count),
      .full     (unused_q_full),
      .empty    (q_empty)
   );

   assign resp_val  = !q_empty;
   assign resp_type = q_head[c_entry_nbits-1];
   assign resp_data = q_head[p_data_nbits-1:0];

`ifdef CMN_SRAM_VALRDY_CTRL_STATS_EN
   // A clear in the same cycle as a fire restarts the counter at that fire.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
      end else begin
         stat_reads  <= stat_clear ? 32'(sram_read_en)
                      : (sram_read_en && stat_reads != '1) ? stat_reads + 1'b1 : stat_reads;
         stat_writes <= stat_clear ? 32'(sram_write_en)
                      : (sram_write_en && stat_writes != '1) ? stat_writes + 1'b1 : stat_writes;
      end
   end
`endif

endmodule

// File: doc/cmn_sram_valrdy_ctrl.md
Name: cmn_sram_valrdy_ctrl

Overview:
- Initiator-side controller for the team's 1rw synchronous SRAM model.
- Accepts latency-insensitive val/rdy memory requests (read/write with byte enables) and drives the SRAM's single port.
- Captures read data one cycle after the access into a response queue and returns in-order val/rdy responses.
- Sits between a processor or accelerator memory port and an SRAM macro or model.

Parameters:
- p_data_nbits, 32, SRAM word width.
- p_num_entries, 256, SRAM depth in words.
- p_resp_depth, 3, response queue entries; minimum 2; 3 needed for full throughput.
- c_addr_nbits, $clog2(p_num_entries), derived; not set externally.
- c_data_nbytes, (p_data_nbits+7)/8, derived; not set externally.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_type  in  1  0 = read, 1 = write.
- req_addr  in  c_addr_nbits  word address.
- req_data  in  p_data_nbits  write data.
- req_byte_en  in  c_data_nbytes  write byte enables.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_type  out  1  echo of request type.
- resp_data  out  p_data_nbits  read data; 0 for writes.
- sram_read_en  out  1  to SRAM read_en.
- sram_read_addr  out  c_addr_nbits  to SRAM read_addr.
- sram_read_data  in  p_data_nbits  from SRAM; valid one cycle after sram_read_en.
- sram_write_en  out  1  to SRAM write_en.
- sram_write_byte_en  out  c_data_nbytes  to SRAM write_byte_en.
- sram_write_addr  out  c_addr_nbits  to SRAM write_addr.
- sram_write_data  out  p_data_nbits  to SRAM write_data.

Behaviour:
- Request fire = req_val && req_rdy.
- SRAM drive: in the fire cycle, SRAM outputs are driven combinationally from req_*.
  - sram_read_en = fire && !req_type; sram_write_en = fire && req_type.
  - Never both enables high in the same cycle.
  - Addresses and data pass straight through; enables are 0 when there is no fire.
- In-flight stage: one register (inflight_val, inflight_type) is set on fire and cleared otherwise.
- Response enqueue: the cycle after fire, the queue enqueues {inflight_type, inflight_type ? 0 : sram_read_data}.
- Latency: request fire in cycle N gives earliest resp_val in cycle N+2.
- Ready rule: req_rdy = reset && (count + inflight_val < p_resp_depth).
  - No combinational path from resp_rdy or resp_val to req_rdy.
  - This guarantees the queue never overflows.
- Queue: circular buffer with wrap-around pointers of $clog2(p_resp_depth) bits and a count register.
  - Pointers wrap to 0 after p_resp_depth-1; non-power-of-two depths are supported.
  - resp_val = (count != 0); head entry drives resp_type and resp_data.
- Simultaneous events: enqueue and dequeue in the same cycle leave count unchanged and move both pointers.
- Full throughput: with resp_rdy held high, one request per cycle is sustained at p_resp_depth >= 3.
- Ordering: responses are strictly in request order.
- Read-after-write to the same address in consecutive fires returns the new data, via SRAM write-then-read across edges.
- Reset (reset = 0, asynchronous):
  - count, pointers and inflight_val go to 0.
  - resp_val = 0, req_rdy = 0, all SRAM enables 0.
  - Queue data is not cleared.
  - Reset mid-operation drops all in-flight and queued responses; read data arriving after reset is discarded.

Optional Feature:
- Macro: CMN_SRAM_VALRDY_CTRL_STATS_EN.
- Defined: adds outputs stat_reads and stat_writes, each 32 bits.
  - Each counts fired reads/writes, saturates at 2^32-1, and is cleared by reset.
  - Adds input stat_clear; a synchronous pulse zeroes both counters, and a fire in the same cycle counts as 1.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cmn_sram_pkg:
  - typedef enum logic {CMN_SRAM_READ, CMN_SRAM_WRITE} cmn_sram_type_t.
  - Parameterised response-entry width helper.
- Sub-module cmn_sram_ctrl_resp_queue: parameterised circular queue (enq, deq, count, full, empty).
  - Reused independently of the controller.

Test Plan:
- Write 0xDEADBEEF to addr 5 with byte_en all 1s, then read addr 5.
  - Response 1: write, data 0. Response 2: read, 0xDEADBEEF.
  - SRAM write_en and read_en are each observed high in exactly one cycle.
- Write 0x11223344 to addr 3, then write 0xAABBCCDD with byte_en 0b0101, then read addr 3 → 0x11BB33DD.
- 8 back-to-back reads with resp_rdy = 1 → req_rdy stays 1 throughout, the first resp_val comes 2 cycles after the first fire, and 8 consecutive responses arrive in order.
- resp_rdy = 0 while reads stream → queue fills and req_rdy drops after exactly 3 fires. Raising resp_rdy then drains 3 responses in order, and req_rdy returns 1 a cycle after the first dequeue.
- Assert reset mid-stream with 2 responses queued and 1 in flight → resp_val is 0 immediately (asynchronous). After release, no stale responses appear and the next read returns correct data.
- With CMN_SRAM_VALRDY_CTRL_STATS_EN: 3 reads plus 2 writes → stat_reads = 3, stat_writes = 2. A stat_clear pulse coinciding with a read fire → stat_reads = 1.
